bus_cmd_arbiter: RTL
====================

Name: bus_cmd_arbiter

Overview:
- Two-requester arbiter in front of the single-transaction register bus master.
- Requesters: the host command decoder (r0) and the on-chip sequencer (r1).
- Grants one command at a time to the master's command sink, then routes the master's response back to the requester that owns the transaction.
- Round-robin fairness; optional lock gives bounded back-to-back ownership for atomic read-modify-write sequences.

Parameters:
- ADDR_W, 14, command/response address width.
- DATA_W, 8, command/response data width.
- MAX_LOCK, 4, maximum consecutive transactions a locking owner may keep the grant (1..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- r0_cmd_stb / r1_cmd_stb  in  1  requester command valid; held until its cmd_ack.
- r0_cmd_ack / r1_cmd_ack  out  1  one-cycle pulse: command accepted downstream.
- r0_cmd_wr / r1_cmd_wr  in  1  1=write, 0=read.
- r0_cmd_a / r1_cmd_a  in  ADDR_W  address.
- r0_cmd_d / r1_cmd_d  in  DATA_W  write data.
- r0_cmd_lock / r1_cmd_lock  in  1  request retention of grant after this transaction.
- r0_rsp_stb / r1_rsp_stb  out  1  response valid to requester.
- r0_rsp_ack / r1_rsp_ack  in  1  requester response accept.
- r0_rsp_wr / r1_rsp_wr, r0_rsp_a / r1_rsp_a, r0_rsp_d / r1_rsp_d  out  1/ADDR_W/DATA_W  response fields.
- m_cmd_stb  out  1  command valid to bus master.
- m_cmd_ack  in  1  bus master command accept.
- m_cmd_wr, m_cmd_a, m_cmd_d  out  1/ADDR_W/DATA_W  registered command fields.
- m_rsp_stb  in  1  bus master response valid.
- m_rsp_ack  out  1  response accept to bus master.
- m_rsp_wr, m_rsp_a, m_rsp_d  in  1/ADDR_W/DATA_W  response fields.
- owner  out  1  index of current or last grantee.
- busy  out  1  high in ISSUE or RESP.

Behaviour:
- Reset (async, rst_n low): state=IDLE, all stb/ack outputs 0, m_cmd_wr/a/d=0, owner=0, rr pointer=0 (r0 preferred), lock counter=0. Reset mid-transaction abandons it; no response is forwarded.
- FSM: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE, winner selection:
  - If lock_active and the owner's cmd_stb=1, the owner wins.
  - Otherwise, if both stb are high, rr pointer picks; else the sole requester wins.
  - If no stb, stay in IDLE.
- IDLE, on a win: register winner wr/a/d into m_cmd_*, set owner, capture the winner's cmd_lock, m_cmd_stb<=1, go to ISSUE. Latency is 1 cycle from stb sampled to m_cmd_stb high.
- ISSUE: m_cmd_* held stable. On m_cmd_ack=1: m_cmd_stb<=0, owner's cmd_ack<=1 for exactly one cycle, go to RESP. The requester must drop stb after that ack. Requester stb changes are ignored during ISSUE and RESP.
- RESP, combinational routing:
  - owner rsp_stb = m_rsp_stb.
  - m_rsp_ack = owner rsp_ack.
  - Both requesters' rsp_wr/a/d = m_rsp_* continuously.
  - The non-owner rsp_stb is always 0.
- RESP, on the cycle m_rsp_stb & m_rsp_ack:
  - Go to IDLE.
  - rr pointer <= ~owner.
  - If the captured lock is 1 and lock counter+1 < MAX_LOCK: lock_active=1 and counter increments. Otherwise lock_active=0 and counter=0.
- m_rsp_stb is ignored outside RESP. The master may hold stb one stale cycle after the handshake; it must not be forwarded, and m_rsp_ack stays 0 then.
- Lock priority applies only in the first IDLE cycle after RESP. If the owner is not requesting then, lock_active clears and normal round-robin applies.
- A simultaneous new request and response handshake is not possible (single outstanding); a new grant occurs no earlier than the cycle after the return to IDLE.
- busy = (state != IDLE).

Test Plan:
- Single read: r0 stb, wr=0, a=0x0123; master acks next cycle, returns d=0x5A -> m_cmd_stb high 1 cycle after stb, r0_cmd_ack 1-cycle pulse, r0_rsp_stb with d=0x5A, r1_rsp_stb stays 0.
- Contention: r0 and r1 both hold stb from reset -> grant order r0, r1, r0, r1 across 4 transactions; owner toggles each time.
- Lock bound: MAX_LOCK=4, r1 lock=1 continuously, r0 also requesting -> r1 gets exactly 4 consecutive grants, then r0 granted.
- Stale master stb: master holds m_rsp_stb one cycle past ack -> no second rsp_stb to the owner, m_rsp_ack=0 in that cycle.
- Backpressure: owner holds rsp_ack=0 for 5 cycles -> m_rsp_ack=0, rsp_stb held, no new grant until ack.
- Reset in RESP: assert rst_n low while r1 awaits a response -> all outputs 0 immediately, owner=0, and the next grant goes to r0 when both requesters request.

Source files
------------

// File: rtl/bus_cmd_arbiter.sv
// bus_cmd_arbiter: two-requester round-robin arbiter with bounded lock in front of a single-transaction bus master.
module bus_cmd_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_cmd_stb,
    output logic              r0_cmd_ack,
    input  logic              r0_cmd_wr,
    input  logic [ADDR_W-1:0] r0_cmd_a,
    input  logic [DATA_W-1:0] r0_cmd_d,
    input  logic              r0_cmd_lock,
    output logic              r0_rsp_stb,
    input  logic              r0_rsp_ack,
    output logic              r0_rsp_wr,
    output logic [ADDR_W-1:0] r0_rsp_a,
    output logic [DATA_W-1:0] r0_rsp_d,
    input  logic              r1_cmd_stb,
    output logic              r1_cmd_ack,
    input  logic              r1_cmd_wr,
    input  logic [ADDR_W-1:0] r1_cmd_a,
    input  logic [DATA_W-1:0] r1_cmd_d,
    input  logic              r1_cmd_lock,
    output logic              r1_rsp_stb,
    input  logic              r1_rsp_ack,
    output logic              r1_rsp_wr,
    output logic [ADDR_W-1:0] r1_rsp_a,
    output logic [DATA_W-1:0] r1_rsp_d,
    output logic              m_cmd_stb,
    input  logic              m_cmd_ack,
    output logic              m_cmd_wr,
    output logic [ADDR_W-1:0] m_cmd_a,
    output logic [DATA_W-1:0] m_cmd_d,
    input  logic              m_rsp_stb,
    output logic              m_rsp_ack,
    input  logic              m_rsp_wr,
    input  logic [ADDR_W-1:0] m_rsp_a,
    input  logic [DATA_W-1:0] m_rsp_d,
    output logic              owner,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t     state, state_nx;
    logic       rr, lock_active, cap_lock, lock_win, go, winner, rsp_hs, lock_ok;
    logic [3:0] lock_cnt;
    always_comb begin
        lock_win = lock_active & (owner ? r1_cmd_stb : r0_cmd_stb);
        go       = r0_cmd_stb | r1_cmd_stb;
        winner   = lock_win ? owner : (r0_cmd_stb & r1_cmd_stb) ? rr : r1_cmd_stb;
        rsp_hs   = (state == RESP) & m_rsp_stb & m_rsp_ack;
        lock_ok  = cap_lock & (lock_cnt + 4'd1 < 4'(MAX_LOCK));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = (state == IDLE && go)         ? ISSUE :
                   (state == ISSUE && m_cmd_ack) ? RESP  :
                   rsp_hs                        ? IDLE  : state;
    end
    always_comb begin
        r0_rsp_stb = (state == RESP) & ~owner & m_rsp_stb;
        r1_rsp_stb = (state == RESP) & owner & m_rsp_stb;
        m_rsp_ack  = (state == RESP) & (owner ? r1_rsp_ack : r0_rsp_ack);
        r0_rsp_wr  = m_rsp_wr;
        r0_rsp_a   = m_rsp_a;
        r0_rsp_d   = m_rsp_d;
        r1_rsp_wr  = m_rsp_wr;
        r1_rsp_a   = m_rsp_a;
        r1_rsp_d   = m_rsp_d;
        busy       = state != IDLE;
    end
    // Lock priority is only honoured in the first IDLE cycle, so lock_active is consumed there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cmd_stb   <= 1'b0;
            m_cmd_wr    <= 1'b0;
            m_cmd_a     <= '0;
            m_cmd_d     <= '0;
            owner       <= 1'b0;
            rr          <= 1'b0;
            lock_active <= 1'b0;
            lock_cnt    <= '0;
            cap_lock    <= 1'b0;
            r0_cmd_ack  <= 1'b0;
            r1_cmd_ack  <= 1'b0;
        end else begin
            r0_cmd_ack <= 1'b0;
            r1_cmd_ack <= 1'b0;
            if (state == IDLE) begin
                lock_active <= 1'b0;
                if (!lock_win) lock_cnt <= '0;
                if (go) begin
                    m_cmd_stb <= 1'b1;
                    m_cmd_wr  <= winner ? r1_cmd_wr : r0_cmd_wr;
                    m_cmd_a   <= winner ? r1_cmd_a : r0_cmd_a;
                    m_cmd_d   <= winner ? r1_cmd_d : r0_cmd_d;
                    owner     <= winner;
                    cap_lock  <= winner ? r1_cmd_lock : r0_cmd_lock;
                end
            end
            if (state == ISSUE && m_cmd_ack) begin
                m_cmd_stb  <= 1'b0;
                r0_cmd_ack <= ~owner;
                r1_cmd_ack <= owner;
            end
            if (rsp_hs) begin
                rr          <= ~owner;
                lock_active <= lock_ok;
                lock_cnt    <= lock_ok ? lock_cnt + 4'd1 : 4'd0;
            end
        end
    end
endmodule
